// File: rtl/commit_trace_pkg.sv
// Shared definitions for the commit trace buffer: data width, record layout and record width.
// The record grows by a 32-bit timestamp field when TRACE_TIMESTAMP_EN is defined.
package commit_trace_pkg;

  localparam int TRACE_XLEN = 32;

  // Bit offsets of each field inside a packed trace record
  localparam int OFF_PC    = 0;
  localparam int OFF_INSTR = OFF_PC + TRACE_XLEN;
  localparam int OFF_ALU   = OFF_INSTR + TRACE_XLEN;
  localparam int OFF_WEN   = OFF_ALU + TRACE_XLEN;
  localparam int OFF_TS    = OFF_WEN + 1;

`ifdef TRACE_TIMESTAMP_EN
  localparam int REC_W = OFF_TS + TRACE_XLEN;
`else
  localparam int REC_W = OFF_TS;
`endif

endpackage

// File: rtl/trace_fifo_mem.sv
// Record storage for the commit trace FIFO: one synchronous write port and one
// asynchronous read port, so the head record falls straight through to the outputs.
module trace_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 97,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_reg [DEPTH];

  // Storage carries no reset; the valid flag in the parent decides what is meaningful
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures one record per retired instruction into a FIFO drained over valid/ready;
// never stalls the core, drops and counts records on overflow. Optional TRACE_TIMESTAMP_EN adds a cycle stamp.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    commit_valid,
  input  logic [TRACE_XLEN-1:0]   commit_pc,
  input  logic [TRACE_XLEN-1:0]   commit_instr,
  input  logic [TRACE_XLEN-1:0]   commit_alu,
  input  logic                    commit_wen,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [TRACE_XLEN-1:0]   trace_pc,
  output logic [TRACE_XLEN-1:0]   trace_instr,
  output logic [TRACE_XLEN-1:0]   trace_alu,
  output logic                    trace_wen,
  output logic [TRACE_XLEN-1:0]   trace_ts,
  output logic [$clog2(DEPTH):0]  count,
  output logic [DROP_W-1:0]       drop_count,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]     PTR_ONE  = 1;
  localparam logic [DROP_W-1:0] DROP_ONE = 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic              valid_reg, valid_next;
  logic [DROP_W-1:0] drop_reg, drop_next;
  logic              ovf_reg, ovf_next;
  logic              full, pop, push, drop;
  logic [REC_W-1:0]  wr_rec, rd_rec;

  // Extra pointer MSB distinguishes full from empty when the low bits coincide
  assign full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  always_comb begin
    pop         = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    drop_next   = drop_reg;
    ovf_next    = ovf_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      drop_next   = '0;
      ovf_next    = 1'b0;
    end else begin
      pop  = valid_reg & trace_ready;
      push = commit_valid & (~full | pop);
      drop = commit_valid & full & ~pop;
      if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      if (drop) begin
        ovf_next = 1'b1;
        if (drop_reg != DROP_MAX) drop_next = drop_reg + DROP_ONE;
      end
    end
    valid_next = (wr_ptr_next != rd_ptr_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      valid_reg  <= 1'b0;
      drop_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      valid_reg  <= valid_next;
      drop_reg   <= drop_next;
      ovf_reg    <= ovf_next;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TRACE_XLEN-1:0] ts_reg;

  // Free-running cycle stamp; only reset clears it, flush leaves it alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_reg <= '0;
    else        ts_reg <= ts_reg + 32'd1;
  end
`endif

  always_comb begin
    wr_rec = '0;
    wr_rec[OFF_PC    +: TRACE_XLEN] = commit_pc;
    wr_rec[OFF_INSTR +: TRACE_XLEN] = commit_instr;
    wr_rec[OFF_ALU   +: TRACE_XLEN] = commit_alu;
    wr_rec[OFF_WEN]                 = commit_wen;
`ifdef TRACE_TIMESTAMP_EN
    wr_rec[OFF_TS    +: TRACE_XLEN] = ts_reg;
`endif
  end

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (REC_W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (wr_rec),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (rd_rec)
  );

  // Head fields are forced to zero while empty so reset and idle present clean data
  assign trace_valid = valid_reg;
  assign trace_pc    = valid_reg ? rd_rec[OFF_PC    +: TRACE_XLEN] : '0;
  assign trace_instr = valid_reg ? rd_rec[OFF_INSTR +: TRACE_XLEN] : '0;
  assign trace_alu   = valid_reg ? rd_rec[OFF_ALU   +: TRACE_XLEN] : '0;
  assign trace_wen   = valid_reg & rd_rec[OFF_WEN];
`ifdef TRACE_TIMESTAMP_EN
  assign trace_ts    = valid_reg ? rd_rec[OFF_TS    +: TRACE_XLEN] : '0;
`else
  assign trace_ts    = '0;
`endif

  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign drop_count = drop_reg;
  assign overflow   = ovf_reg;

endmodule
